wb_arbiter: RTL and testbench

//  Writeback arbiter. Sits between the functional units (ALU, branch, mul/div, LSQ) and the

---
 rtl/wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter between the functional units and the single ROB writeback
// port. Each source has its own small FIFO. A round-robin arbiter picks one
// non-empty FIFO per cycle, and the picked head is registered onto the wb_* bus.
// Sources see ready/valid backpressure. The ROB side always accepts.
//
// Parameters
//   NUM_SRC   number of writeback sources (2..8)
//   DEPTH     entries per source FIFO (power of 2, >= 2)
//
// Ports
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   rob_flush    synchronous flush: empties the FIFOs, drops offered beats,
//                and suppresses the grant
//   src_valid    per-source result valid
//   src_ready    per-source FIFO not full (registered state only)
//   src_error    per-source exception flag
//   src_ecause   per-source exception cause, source i at [5i+4:5i]
//   src_robid    per-source ROB index,       source i at [7i+6:7i]
//   src_result   per-source result,          source i at [32i+31:32i]
//   wb_valid     writeback valid to the ROB
//   wb_error     writeback exception flag
//   wb_ecause    writeback exception cause
//   wb_robid     writeback ROB index
//   wb_result    writeback result
//   wb_busy      high when wb_valid is high or any FIFO holds data
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rob_flush,
    input  logic [NUM_SRC-1:0]      src_valid,
    output logic [NUM_SRC-1:0]      src_ready,
    input  logic [NUM_SRC-1:0]      src_error,
    input  logic [5*NUM_SRC-1:0]    src_ecause,
    input  logic [7*NUM_SRC-1:0]    src_robid,
    input  logic [32*NUM_SRC-1:0]   src_result,
    output logic                    wb_valid,
    output logic                    wb_error,
    output logic [4:0]              wb_ecause,
    output logic [6:0]              wb_robid,
    output logic [31:0]             wb_result,
    output logic                    wb_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NUM_SRC);
    localparam int EW = 1 + 5 + 7 + 32;     // {error, ecause, robid, result}

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [PW:0] NSRC_W  = (PW+1)'(NUM_SRC);

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] not_empty;
    logic [NUM_SRC-1:0] not_full;
    logic [EW-1:0]      head [NUM_SRC];

    logic [PW-1:0]      rr_ptr_reg;
    logic [PW-1:0]      grant_idx;
    logic               grant_valid;

    logic               wb_valid_reg;
    logic               wb_error_reg;
    logic [4:0]         wb_ecause_reg;
    logic [6:0]         wb_robid_reg;
    logic [31:0]        wb_result_reg;

    // -------------------------------------------------------------------------
    // Per-source FIFOs. The pointers carry one extra polarity bit, so that
    // full and empty can be told apart when the index bits are equal.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
            logic [AW:0]   wr_ptr_reg;
            logic [AW:0]   rd_ptr_reg;
            logic [EW-1:0] mem [DEPTH];

            assign not_empty[gi] = (wr_ptr_reg != rd_ptr_reg);
            assign not_full[gi]  = !((wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                                     (wr_ptr_reg[AW]     != rd_ptr_reg[AW]));

            // Beats offered during a flush are dropped even when ready is high.
            assign push[gi] = src_valid[gi] & not_full[gi] & ~rob_flush;
            assign pop[gi]  = grant_valid && (grant_idx == PW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else if (rob_flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                end
            end

            // The storage is not reset. An entry is read only after it is written.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg[AW-1:0]] <= {src_error[gi],
                                                src_ecause[5*gi +: 5],
                                                src_robid[7*gi +: 7],
                                                src_result[32*gi +: 32]};
                end
            end

            assign head[gi] = mem[rd_ptr_reg[AW-1:0]];
        end
    endgenerate

    assign src_ready = not_full;

    // -------------------------------------------------------------------------
    // Round-robin arbitration. The search starts at the source after the last
    // grant. A flush cycle issues no grant, so nothing pops while the FIFOs clear.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [PW:0] sum;
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            sum = {1'b0, rr_ptr_reg} + (PW+1)'(k);
            if (sum >= NSRC_W) sum = sum - NSRC_W;
            if (!grant_valid && not_empty[sum[PW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = sum[PW-1:0];
            end
        end
        if (rob_flush) grant_valid = 1'b0;
    end

    // After reset the pointer is set to the last source, so source 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= PW'(NUM_SRC - 1);
        end else if (grant_valid) begin
            rr_ptr_reg <= grant_idx;
        end
    end

    // -------------------------------------------------------------------------
    // Registered writeback bus. The payload fields hold their value when there
    // is no grant. Only wb_valid drops.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_reg  <= 1'b0;
            wb_error_reg  <= 1'b0;
            wb_ecause_reg <= '0;
            wb_robid_reg  <= '0;
            wb_result_reg <= '0;
        end else if (grant_valid) begin
            wb_valid_reg  <= 1'b1;
            {wb_error_reg, wb_ecause_reg, wb_robid_reg, wb_result_reg} <= head[grant_idx];
        end else begin
            wb_valid_reg  <= 1'b0;
        end
    end

    assign wb_valid  = wb_valid_reg;
    assign wb_error  = wb_error_reg;
    assign wb_ecause = wb_ecause_reg;
    assign wb_robid  = wb_robid_reg;
    assign wb_result = wb_result_reg;
    assign wb_busy   = wb_valid_reg | (|not_empty);

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed testbench for wb_arbiter with NUM_SRC=4 and DEPTH=2. Inputs are driven
// 1 time unit after the rising edge. Outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rob_flush = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    src_ready;
    logic [N-1:0]    src_error = '0;
    logic [5*N-1:0]  src_ecause = '0;
    logic [7*N-1:0]  src_robid = '0;
    logic [32*N-1:0] src_result = '0;
    logic            wb_valid;
    logic            wb_error;
    logic [4:0]      wb_ecause;
    logic [6:0]      wb_robid;
    logic [31:0]     wb_result;
    logic            wb_busy;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.NUM_SRC(N), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rob_flush  (rob_flush),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_error  (src_error),
        .src_ecause (src_ecause),
        .src_robid  (src_robid),
        .src_result (src_result),
        .wb_valid   (wb_valid),
        .wb_error   (wb_error),
        .wb_ecause  (wb_ecause),
        .wb_robid   (wb_robid),
        .wb_result  (wb_result),
        .wb_busy    (wb_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic err, input logic [4:0] ec,
                            input logic [6:0] rid, input logic [31:0] res);
        src_error[i]          = err;
        src_ecause[5*i +: 5]  = ec;
        src_robid[7*i +: 7]   = rid;
        src_result[32*i +: 32] = res;
        src_valid[i]          = 1'b1;
    endtask

    task automatic do_reset();
        src_valid = '0;
        rob_flush = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid); end
        checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL reset_wb_error got %0b want 0", wb_error); end
        checks++; if (wb_ecause !== 5'd0) begin errors++; $display("FAIL reset_wb_ecause got %0d want 0", wb_ecause); end
        checks++; if (wb_robid !== 7'd0) begin errors++; $display("FAIL reset_wb_robid got %0d want 0", wb_robid); end
        checks++; if (wb_result !== 32'd0) begin errors++; $display("FAIL reset_wb_result got %h want 0", wb_result); end
        checks++; if (src_ready !== 4'hF) begin errors++; $display("FAIL reset_src_ready got %b want 1111", src_ready); end
        checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL reset_wb_busy got %0b want 0", wb_busy); end
        $display("reset: wb_valid=%0b src_ready=%b busy=%0b", wb_valid, src_ready, wb_busy);
    endtask

    task automatic test_single_beat();
        do_reset();
        set_beat(0, 1'b0, 5'd0, 7'd5, 32'hDEAD_BEEF);
        tick();                                   // edge 0: beat accepted
        src_valid = '0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", wb_valid); end
        checks++; if (wb_busy !== 1'b1) begin errors++; $display("FAIL single_busy_queued got %0b want 1", wb_busy); end
        tick();                                   // edge 1: writeback
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", wb_valid); end
        checks++; if (wb_robid !== 7'd5) begin errors++; $display("FAIL single_robid got %0d want 5", wb_robid); end
        checks++; if (wb_result !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_result got %h want deadbeef", wb_result); end
        $display("single: wb robid=%0d result=%h", wb_robid, wb_result);
        tick();                                   // edge 2
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %0b want 0", wb_valid); end
        checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop got %0b want 0", wb_busy); end
    endtask

    task automatic test_all_sources();
        do_reset();
        for (int i = 0; i < N; i++) set_beat(i, 1'b0, 5'd0, 7'(10 + i), 32'(100 + i));
        tick();
        src_valid = '0;
        for (int n = 0; n < N; n++) begin
            tick();
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL all_valid[%0d] got %0b want 1", n, wb_valid); end
            checks++; if (wb_robid !== 7'(10 + n)) begin errors++; $display("FAIL all_order[%0d] robid got %0d want %0d", n, wb_robid, 10 + n); end
            checks++; if (wb_busy !== 1'b1) begin errors++; $display("FAIL all_busy[%0d] got %0b want 1", n, wb_busy); end
            $display("all: wb robid=%0d result=%0d", wb_robid, wb_result);
        end
        tick();
        checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL all_busy_end got %0b want 0", wb_busy); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL all_valid_end got %0b want 0", wb_valid); end
    endtask

    task automatic test_alternate();
        int seq_in [N];
        int seq_out [N];
        logic acc1, acc2;
        int exp_src;
        do_reset();
        for (int i = 0; i < N; i++) begin seq_in[i] = 0; seq_out[i] = 0; end
        for (int c = 0; c < 10; c++) begin
            set_beat(1, 1'b0, 5'd0, {3'd1, 4'(seq_in[1])}, 32'(c));
            set_beat(2, 1'b0, 5'd0, {3'd2, 4'(seq_in[2])}, 32'(c));
            if (c >= 2) begin
                // FIFO 2 is full after odd edges, and FIFO 1 after even edges.
                checks++; if (src_ready[1] !== ((c % 2) == 0)) begin errors++; $display("FAIL alt_ready1[c%0d] got %0b want %0b", c, src_ready[1], (c % 2) == 0); end
                checks++; if (src_ready[2] !== ((c % 2) == 1)) begin errors++; $display("FAIL alt_ready2[c%0d] got %0b want %0b", c, src_ready[2], (c % 2) == 1); end
            end
            acc1 = src_ready[1];
            acc2 = src_ready[2];
            tick();
            if (acc1) seq_in[1]++;
            if (acc2) seq_in[2]++;
            if (c >= 1) begin
                exp_src = (c % 2 == 1) ? 1 : 2;
                checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alt_valid[c%0d] got %0b want 1", c, wb_valid); end
                checks++; if (wb_robid[6:4] !== 3'(exp_src)) begin errors++; $display("FAIL alt_src[c%0d] got %0d want %0d", c, wb_robid[6:4], exp_src); end
                checks++; if (wb_robid[3:0] !== 4'(seq_out[exp_src])) begin errors++; $display("FAIL alt_seq[c%0d] got %0d want %0d", c, wb_robid[3:0], seq_out[exp_src]); end
                seq_out[exp_src]++;
                $display("alt: wb src=%0d seq=%0d", wb_robid[6:4], wb_robid[3:0]);
            end
        end
        src_valid = '0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < N; i++) set_beat(i, 1'b0, 5'd0, 7'(20 + i), 32'(i));
        tick();
        tick();
        src_valid = '0;
        checks++; if (src_ready !== 4'b0001) begin errors++; $display("FAIL flush_prefill_ready got %b want 0001", src_ready); end
        checks++; if (wb_valid !== 1'b1 || wb_robid !== 7'd20) begin errors++; $display("FAIL flush_prefill_wb got v=%0b robid=%0d want v=1 robid=20", wb_valid, wb_robid); end
        rob_flush = 1'b1;
        set_beat(0, 1'b0, 5'd0, 7'd99, 32'h9999_9999);
        tick();
        rob_flush = 1'b0;
        src_valid = '0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", wb_valid); end
        checks++; if (src_ready !== 4'hF) begin errors++; $display("FAIL flush_ready got %b want 1111", src_ready); end
        checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", wb_busy); end
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_late_wb[%0d] got v=%0b robid=%0d want v=0", n, wb_valid, wb_robid); end
        end
        $display("flush: wb_valid=%0b src_ready=%b", wb_valid, src_ready);
    endtask

    task automatic test_exception();
        do_reset();
        set_beat(1, 1'b1, 5'd2, 7'd127, 32'h1234_5678);
        tick();
        src_valid = '0;
        tick();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL exc_valid got %0b want 1", wb_valid); end
        checks++; if (wb_error !== 1'b1) begin errors++; $display("FAIL exc_error got %0b want 1", wb_error); end
        checks++; if (wb_ecause !== 5'd2) begin errors++; $display("FAIL exc_ecause got %0d want 2", wb_ecause); end
        checks++; if (wb_robid !== 7'd127) begin errors++; $display("FAIL exc_robid got %0d want 127", wb_robid); end
        checks++; if (wb_result !== 32'h1234_5678) begin errors++; $display("FAIL exc_result got %h want 12345678", wb_result); end
        $display("exc: wb err=%0b ecause=%0d robid=%0d", wb_error, wb_ecause, wb_robid);
        // The cause field is forwarded unchanged even when no error is flagged.
        set_beat(0, 1'b0, 5'd9, 7'd64, 32'hCAFE_F00D);
        tick();
        src_valid = '0;
        tick();
        checks++; if (wb_error !== 1'b0) begin errors++; $display("FAIL noexc_error got %0b want 0", wb_error); end
        checks++; if (wb_ecause !== 5'd9) begin errors++; $display("FAIL noexc_ecause got %0d want 9", wb_ecause); end
        checks++; if (wb_robid !== 7'd64 || wb_result !== 32'hCAFE_F00D) begin errors++; $display("FAIL noexc_payload got robid=%0d result=%h want 64 cafef00d", wb_robid, wb_result); end
        $display("noexc: wb err=%0b ecause=%0d robid=%0d", wb_error, wb_ecause, wb_robid);
    endtask

    task automatic test_async_reset();
        do_reset();
        set_beat(2, 1'b1, 5'd3, 7'd33, 32'h3333_0000);
        tick();
        src_valid = '0;
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_robid !== 7'd33) begin errors++; $display("FAIL arst_pre got v=%0b robid=%0d want v=1 robid=33", wb_valid, wb_robid); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", wb_valid); end
        checks++; if (wb_robid !== 7'd0 || wb_result !== 32'd0 || wb_error !== 1'b0) begin errors++; $display("FAIL arst_fields got robid=%0d result=%h err=%0b want 0", wb_robid, wb_result, wb_error); end
        checks++; if (wb_busy !== 1'b0 || src_ready !== 4'hF) begin errors++; $display("FAIL arst_busy_ready got busy=%0b ready=%b want 0 1111", wb_busy, src_ready); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_beat(i, 1'b0, 5'd0, 7'(40 + i), 32'(i));
        tick();
        src_valid = '0;
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_robid !== 7'd40) begin errors++; $display("FAIL arst_first_grant got v=%0b robid=%0d want v=1 robid=40", wb_valid, wb_robid); end
        tick();
        checks++; if (wb_robid !== 7'd41) begin errors++; $display("FAIL arst_second_grant got robid=%0d want 41", wb_robid); end
        $display("arst: post-reset grants robid=40 then %0d", wb_robid);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_all_sources();
        test_alternate();
        test_flush();
        test_exception();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
